regfile_mp_sb: RTL and testbench

- Parametrised multi-port integer register file for the pipelined core.
- Generalises the single-write, two-read file to NREAD read ports and NWRITE write ports.
- Adds optional same-cycle write-to-read bypass and a per-register pending-write scoreboard. Issue uses the scoreboard for RAW hazard detection; writeback retires entries.
- Sits between decode/issue (reads, alloc) and writeback (writes).

---
 rtl/regfile_mp_sb.sv | 105 ++++++++++
 tb/tb_regfile_mp_sb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with optional write-to-read bypass and a pending-write scoreboard.
// Reads are combinational (0 cycles); writes, busy bits and busy_cnt commit at the clock edge; no backpressure.
module regfile_mp_sb #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREAD*AW-1:0]      rs_addr,
    output logic [NREAD*XLEN-1:0]    rs_data,
    output logic [NREAD-1:0]         rs_busy,
    input  logic [NWRITE-1:0]        wr_en,
    input  logic [NWRITE*AW-1:0]     wr_addr,
    input  logic [NWRITE*XLEN-1:0]   wr_data,
    input  logic [NWRITE-1:0]        wr_clr,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    input  logic                     flush,
    output logic [AW:0]              busy_cnt
);

    localparam int CW = AW + 1;

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [NREG-1:0]           clr_vec;
    logic [CW-1:0]             busy_cnt_q, busy_cnt_d;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Ports are walked in ascending order so the highest-indexed hit wins both data and clr.
    always_comb begin
        regs_d  = regs_q;
        clr_vec = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && !is_zero(wr_addr[j*AW +: AW])) begin
                regs_d[wr_addr[j*AW +: AW]]  = wr_data[j*XLEN +: XLEN];
                clr_vec[wr_addr[j*AW +: AW]] = wr_clr[j];
            end
        end
    end

    // Priority flush > alloc > clr: a producer allocated this cycle outlives a retiring one.
    always_comb begin
        busy_d = busy_q & ~clr_vec;
        if (alloc_en && !is_zero(alloc_addr)) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Busy status is deliberately not bypassed: issue sees the scoreboard as of the last edge.
    always_comb begin
        logic [AW-1:0]   rd_a;
        logic [XLEN-1:0] rd_v;
        rs_data = '0;
        rs_busy = '0;
        rd_a    = '0;
        rd_v    = '0;
        for (int k = 0; k < NREAD; k++) begin
            rd_a = rs_addr[k*AW +: AW];
            rd_v = regs_q[rd_a];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_a)) begin
                        rd_v = wr_data[j*XLEN +: XLEN];
                    end
                end
            end
            if (is_zero(rd_a)) begin
                rd_v = '0;
            end
            rs_data[k*XLEN +: XLEN] = rd_v;
            rs_busy[k]              = busy_q[rd_a];
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: two instances (bypass on / off) share stimulus and are checked against an array model.
module tb_regfile_mp_sb;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int NREAD  = 2;
    localparam int NWRITE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREAD*AW-1:0]    rs_addr;
    logic [NWRITE-1:0]      wr_en;
    logic [NWRITE*AW-1:0]   wr_addr;
    logic [NWRITE*XLEN-1:0] wr_data;
    logic [NWRITE-1:0]      wr_clr;
    logic                   alloc_en;
    logic [AW-1:0]          alloc_addr;
    logic                   flush;

    logic [NREAD*XLEN-1:0]  rs_data, rs_data_nb;
    logic [NREAD-1:0]       rs_busy, rs_busy_nb;
    logic [AW:0]            busy_cnt, busy_cnt_nb;

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NREAD(NREAD), .NWRITE(NWRITE),
                    .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_cnt(busy_cnt));

    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NREAD(NREAD), .NWRITE(NWRITE),
                    .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(rs_data_nb), .rs_busy(rs_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_clr(wr_clr),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush), .busy_cnt(busy_cnt_nb));

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    logic [XLEN-1:0] mreg  [NREG];
    bit              mbusy [NREG];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input int k, input bit byp);
        int a;
        logic [XLEN-1:0] v;
        a = int'(rs_addr[k*AW +: AW]);
        if (a == 0) return '0;
        v = mreg[a];
        if (byp) begin
            for (int j = NWRITE - 1; j >= 0; j--) begin
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                    return wr_data[j*XLEN +: XLEN];
                end
            end
        end
        return v;
    endfunction

    function automatic int mcount();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    // Reference: per register, the highest-indexed enabled writer decides data and clr.
    always @(posedge clk or posedge rst) begin : model
        logic [XLEN-1:0] nreg [NREG];
        bit nb [NREG];
        bit claimed [NREG];
        int a;
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mreg[i]  <= '0;
                mbusy[i] <= 1'b0;
            end
        end else begin
            nreg    = mreg;
            nb      = mbusy;
            claimed = '{default: 1'b0};
            for (int j = NWRITE - 1; j >= 0; j--) begin
                a = int'(wr_addr[j*AW +: AW]);
                if (wr_en[j] && a != 0 && !claimed[a]) begin
                    claimed[a] = 1'b1;
                    nreg[a]    = wr_data[j*XLEN +: XLEN];
                    if (wr_clr[j]) nb[a] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != '0) nb[int'(alloc_addr)] = 1'b1;
            if (flush) nb = '{default: 1'b0};
            mreg  <= nreg;
            mbusy <= nb;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < NREAD; k++) begin
                int a;
                a = int'(rs_addr[k*AW +: AW]);
                chk($sformatf("rd%0d_byp", k), rs_data[k*XLEN +: XLEN], exp_rd(k, 1'b1));
                chk($sformatf("rd%0d_nobyp", k), rs_data_nb[k*XLEN +: XLEN], exp_rd(k, 1'b0));
                chk($sformatf("busy%0d", k), rs_busy[k], (a == 0) ? 1'b0 : mbusy[a]);
                chk($sformatf("busy%0d_nb", k), rs_busy_nb[k], (a == 0) ? 1'b0 : mbusy[a]);
            end
            chk("busy_cnt", busy_cnt, mcount());
            chk("busy_cnt_nb", busy_cnt_nb, mcount());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_clr   = '0;
        alloc_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic set_rd(input int k, input int a);
        rs_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int j, input int a, input logic [XLEN-1:0] d, input bit c);
        wr_en[j]                 = 1'b1;
        wr_addr[j*AW +: AW]      = AW'(a);
        wr_data[j*XLEN +: XLEN]  = d;
        wr_clr[j]                = c;
    endtask

    task automatic alloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = AW'(a);
    endtask

    initial begin
        rs_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_addr = '0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_cnt", busy_cnt, 0);
        chk("reset_data", rs_data, 0);
        chk("reset_busy", rs_busy, 0);
        rst    = 1'b0;
        cmp_on = 1'b1;

        // Preload, then reset asynchronously in the middle of a cycle.
        wr(0, 5, 32'hDEADBEEF, 1'b0);
        alloc(8);
        tick();
        idle();
        set_rd(0, 5);
        #1;
        chk("preload", rs_data[31:0], 32'hDEADBEEF);
        chk("preload_cnt", busy_cnt, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_data", rs_data[31:0], 0);
        chk("arst_cnt", busy_cnt, 0);
        tick();
        rst = 1'b0;

        // Same-cycle write-to-read bypass versus stored-only reads.
        wr(0, 7, 32'h1234, 1'b0);
        set_rd(1, 7);
        #1;
        chk("bypass_same", rs_data[63:32], 32'h1234);
        chk("nobypass_old", rs_data_nb[63:32], 0);
        tick();
        idle();
        #1;
        chk("nobypass_next", rs_data_nb[63:32], 32'h1234);

        wr(0, 3, 32'hAAAA, 1'b0);
        wr(1, 3, 32'h5555, 1'b0);
        tick();
        idle();
        set_rd(0, 3);
        #1;
        chk("collision", rs_data[31:0], 32'h5555);

        alloc(9);
        tick();
        idle();
        set_rd(0, 9);
        #1;
        chk("alloc_busy", rs_busy[0], 1);
        chk("alloc_cnt", busy_cnt, 1);
        wr(0, 9, 32'h11, 1'b1);
        alloc(9);
        tick();
        idle();
        #1;
        chk("realloc_busy", rs_busy[0], 1);
        chk("realloc_cnt", busy_cnt, 1);
        wr(0, 9, 32'h22, 1'b1);
        tick();
        idle();
        #1;
        chk("retire_busy", rs_busy[0], 0);
        chk("retire_cnt", busy_cnt, 0);
        chk("retire_data", rs_data[31:0], 32'h22);

        for (int i = 1; i <= 4; i++) begin
            alloc(i);
            tick();
        end
        idle();
        #1;
        chk("four_alloc_cnt", busy_cnt, 4);
        flush = 1'b1;
        alloc(6);
        tick();
        idle();
        set_rd(1, 6);
        #1;
        chk("flush_cnt", busy_cnt, 0);
        chk("flush_x6_busy", rs_busy[1], 0);

        alloc(2);
        tick();
        idle();
        wr(1, 0, 32'hFFFF_FFFF, 1'b1);
        alloc(0);
        set_rd(0, 0);
        set_rd(1, 0);
        #1;
        chk("zero_byp0", rs_data[31:0], 0);
        chk("zero_byp1", rs_data[63:32], 0);
        tick();
        idle();
        #1;
        chk("zero_read", rs_data[31:0], 0);
        chk("zero_busy", rs_busy[0], 0);
        chk("zero_cnt", busy_cnt, 1);
        chk("model_cnt", mcount(), 1);
        chk("model_x3", mreg[3], 32'h5555);

        // Randomized traffic; narrow address range forces collisions and read/write overlap.
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < NWRITE; j++) begin
                wr_en[j]                = ($urandom_range(0, 2) != 0);
                wr_clr[j]               = $urandom_range(0, 1) == 1;
                wr_addr[j*AW +: AW]     = AW'($urandom_range(0, (n % 4 == 0) ? 31 : 7));
                wr_data[j*XLEN +: XLEN] = $urandom;
            end
            for (int k = 0; k < NREAD; k++) begin
                rs_addr[k*AW +: AW] = AW'($urandom_range(0, (n % 4 == 1) ? 31 : 7));
            end
            alloc_en   = ($urandom_range(0, 2) != 0);
            alloc_addr = AW'($urandom_range(0, (n % 3 == 0) ? 31 : 7));
            flush      = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 150) == 0) begin
                #2 rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        idle();
        tick();
        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
